// File: rtl/fwd_bypass_net.sv
// fwd_bypass_net: EX-stage operand bypass network.
// Tracks in-flight GPR writes in a tag/data shift pipeline (entry 0 = MEM),
// forwards youngest matches to NREAD read channels, flags load-use stalls,
// and drives the register-file write port from the last entry.
// Legal parameters: NSTAGE 2..6, NREAD 1..4, 0 <= LATE_IDX < NSTAGE.
// Optional feature: define FWD_HILO_EN to track and forward HI/LO writes.
module fwd_bypass_net #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NSTAGE   = 3,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned LATE_IDX = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    adv,
  input  logic                    ex_wr,
  input  logic [4:0]              ex_waddr,
  input  logic [DATA_W-1:0]       ex_wdata,
  input  logic                    ex_ready,
  input  logic                    late_valid,
  input  logic [DATA_W-1:0]       late_data,
  input  logic [NREAD*5-1:0]      rd_addr,
  input  logic [NREAD*DATA_W-1:0] rd_rf,
  output logic [NREAD*DATA_W-1:0] rd_data,
  output logic [NREAD-1:0]        rd_hit,
  output logic                    stall,
`ifdef FWD_HILO_EN
  input  logic                    ex_hilo_wr,
  input  logic [DATA_W-1:0]       ex_hi,
  input  logic [DATA_W-1:0]       ex_lo,
  input  logic [DATA_W-1:0]       rf_hi,
  input  logic [DATA_W-1:0]       rf_lo,
  output logic [DATA_W-1:0]       hi_fwd,
  output logic [DATA_W-1:0]       lo_fwd,
  output logic                    wb_hilo_we,
  output logic [DATA_W-1:0]       wb_hi,
  output logic [DATA_W-1:0]       wb_lo,
`endif
  output logic                    wb_we,
  output logic [4:0]              wb_waddr,
  output logic [DATA_W-1:0]       wb_wdata
);

  localparam int unsigned LAST = NSTAGE - 1;

  logic [NSTAGE-1:0] valid_q, valid_d;
  logic [NSTAGE-1:0] ready_q, ready_d;
  logic [4:0]        waddr_q [NSTAGE];
  logic [4:0]        waddr_d [NSTAGE];
  logic [DATA_W-1:0] data_q  [NSTAGE];
  logic [DATA_W-1:0] data_d  [NSTAGE];

  // Effective (late-patched) view of ready/data used by reads, shift and write-back
  logic [NSTAGE-1:0] ready_e;
  logic [DATA_W-1:0] data_e  [NSTAGE];

  // Late-result patch of entry[LATE_IDX]; ignored for invalid or already-ready entries
  always_comb begin
    ready_e = ready_q;
    data_e  = data_q;
    if (late_valid && valid_q[LATE_IDX] && !ready_q[LATE_IDX]) begin
      ready_e[LATE_IDX] = 1'b1;
      data_e[LATE_IDX]  = late_data;
    end
  end

  // Next state: shift on adv (patched copy moves along), otherwise hold with patch stored in place
  always_comb begin
    valid_d = valid_q;
    ready_d = ready_e;
    waddr_d = waddr_q;
    data_d  = data_e;
    if (adv) begin
      valid_d[0] = ex_wr && (ex_waddr != 5'd0);
      waddr_d[0] = ex_waddr;
      ready_d[0] = ex_ready;
      data_d[0]  = ex_wdata;
      for (int unsigned i = 1; i < NSTAGE; i++) begin
        valid_d[i] = valid_q[i-1];
        waddr_d[i] = waddr_q[i-1];
        ready_d[i] = ready_e[i-1];
        data_d[i]  = data_e[i-1];
      end
    end
  end

  // Entry pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      ready_q <= '0;
      for (int unsigned i = 0; i < NSTAGE; i++) begin
        waddr_q[i] <= 5'd0;
        data_q[i]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      ready_q <= ready_d;
      waddr_q <= waddr_d;
      data_q  <= data_d;
    end
  end

  // Per-channel youngest-match forwarding; a not-ready youngest match stalls and shadows older ones
  always_comb begin : rd_mux
    logic [4:0]        ra;
    logic              fnd;
    logic              frdy;
    logic [DATA_W-1:0] fdat;
    rd_data = '0;
    rd_hit  = '0;
    stall   = 1'b0;
    ra      = 5'd0;
    fnd     = 1'b0;
    frdy    = 1'b0;
    fdat    = '0;
    for (int unsigned c = 0; c < NREAD; c++) begin
      ra   = rd_addr[c*5 +: 5];
      fnd  = 1'b0;
      frdy = 1'b0;
      fdat = '0;
      for (int unsigned i = 0; i < NSTAGE; i++) begin
        if (!fnd && valid_q[i] && (waddr_q[i] == ra) && (ra != 5'd0)) begin
          fnd  = 1'b1;
          frdy = ready_e[i];
          fdat = data_e[i];
        end
      end
      rd_hit[c] = fnd;
      rd_data[c*DATA_W +: DATA_W] = (fnd && frdy) ? fdat : rd_rf[c*DATA_W +: DATA_W];
      stall = stall | (fnd & ~frdy);
    end
  end

  // Register-file write port; a valid but not-ready last entry is dropped
  always_comb begin
    wb_we    = valid_q[LAST] && ready_e[LAST];
    wb_waddr = waddr_q[LAST];
    wb_wdata = data_e[LAST];
  end

`ifdef FWD_HILO_EN
  logic [NSTAGE-1:0] hilo_q, hilo_d;
  logic [DATA_W-1:0] hi_q [NSTAGE];
  logic [DATA_W-1:0] hi_d [NSTAGE];
  logic [DATA_W-1:0] lo_q [NSTAGE];
  logic [DATA_W-1:0] lo_d [NSTAGE];

  // HI/LO fields shift alongside the GPR entries
  always_comb begin
    hilo_d = hilo_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (adv) begin
      hilo_d[0] = ex_hilo_wr;
      hi_d[0]   = ex_hi;
      lo_d[0]   = ex_lo;
      for (int unsigned i = 1; i < NSTAGE; i++) begin
        hilo_d[i] = hilo_q[i-1];
        hi_d[i]   = hi_q[i-1];
        lo_d[i]   = lo_q[i-1];
      end
    end
  end

  // HI/LO entry registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hilo_q <= '0;
      for (int unsigned i = 0; i < NSTAGE; i++) begin
        hi_q[i] <= '0;
        lo_q[i] <= '0;
      end
    end else begin
      hilo_q <= hilo_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  // Youngest HI/LO producer wins; HI/LO results are always final, so no stall
  always_comb begin : hilo_mux
    logic hfnd;
    hfnd   = 1'b0;
    hi_fwd = rf_hi;
    lo_fwd = rf_lo;
    for (int unsigned i = 0; i < NSTAGE; i++) begin
      if (!hfnd && hilo_q[i]) begin
        hfnd   = 1'b1;
        hi_fwd = hi_q[i];
        lo_fwd = lo_q[i];
      end
    end
    wb_hilo_we = hilo_q[LAST];
    wb_hi      = hi_q[LAST];
    wb_lo      = lo_q[LAST];
  end
`endif

endmodule
